// File: rtl/des_pkg.sv
// Shared DES constants and helpers: permutation tables, key shift schedule,
// S-boxes, the control state enum and MSB-first permutation functions.
package des_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Each S-box is stored row-major: entry index = {row(b1,b6), col(b2..b5)}.
    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    // DES bit n of a W-bit vector lives at index W-n (bit 1 is the MSB).
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_TBL[i]];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_TBL[i]];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TBL[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_TBL[i]];
        return y;
    endfunction

    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  b;
        for (int i = 0; i < 8; i++) begin
            b = x[47-6*i -: 6];
            y[31-4*i -: 4] = 4'(SBOX[i][{b[5], b[0], b[4:1]}]);
        end
        return y;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        return (n == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        return (n == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L xor P(S(E(R) xor K)).
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] l_next,
    output logic [31:0] r_next
);

    assign l_next = r;
    assign r_next = l ^ perm_p(sbox_sub(perm_e(r) ^ k));

endmodule

// File: rtl/des_encrypt.sv
// Iterative DES core, one Feistel round per clock, 16 rounds per block.
// Define DES_DECRYPT_EN to add a decrypt input that reverses the subkey order.
module des_encrypt
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
`ifdef DES_DECRYPT_EN
    input  logic        decrypt,
`endif
    input  logic [63:0] data,
    input  logic        data_vld,
    input  logic [63:0] key,
    output logic [63:0] result,
    output logic        result_vld
);

    state_t      state;
    logic [4:0]  cnt;
    logic [3:0]  rnd;
    logic [31:0] l_q, r_q, l_nx, r_nx;
    logic [27:0] c_q, d_q, c_nx, d_nx;
    logic [47:0] sub_key;
`ifdef DES_DECRYPT_EN
    logic        dec_q;
`endif

    assign rnd = 4'(cnt - 5'd1);

    // NOTE: the encrypt rotation is assigned first so every path through this block drives c_nx/d_nx and no latch is inferred.
    always_comb begin
        c_nx = rotl28(c_q, SHIFT_TBL[rnd]);
        d_nx = rotl28(d_q, SHIFT_TBL[rnd]);
`ifdef DES_DECRYPT_EN
        // Decrypt walks the schedule backwards: C0D0 already equals C16D16.
        if (dec_q) begin
            if (rnd == 4'd0) begin
                c_nx = c_q;
                d_nx = d_q;
            end else begin
                c_nx = rotr28(c_q, SHIFT_TBL[4'(5'd16 - {1'b0, rnd})]);
                d_nx = rotr28(d_q, SHIFT_TBL[4'(5'd16 - {1'b0, rnd})]);
            end
        end
`endif
    end

    assign sub_key = perm_pc2({c_nx, d_nx});

    des_round u_round (
        .l      (l_q),
        .r      (r_q),
        .k      (sub_key),
        .l_next (l_nx),
        .r_next (r_nx)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values, matching the hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            l_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            result     <= '0;
            result_vld <= 1'b0;
`ifdef DES_DECRYPT_EN
            dec_q      <= 1'b0;
`endif
        end else begin
            result_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_vld) begin
                        {l_q, r_q} <= perm_ip(data);
                        {c_q, d_q} <= perm_pc1(key);
                        cnt        <= 5'd1;
                        state      <= RUN;
`ifdef DES_DECRYPT_EN
                        dec_q      <= decrypt;
`endif
                    end
                end
                RUN: begin
                    l_q <= l_nx;
                    r_q <= r_nx;
                    c_q <= c_nx;
                    d_q <= d_nx;
                    if (cnt == 5'd16) begin
                        // Halves are swapped before the final permutation.
                        result     <= perm_fp({r_nx, l_nx});
                        result_vld <= 1'b1;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_encrypt.sv
// Self-checking bench for des_encrypt: known answers, random blocks against a
// table-driven DES model, busy-ignore, back-to-back and mid-block reset.
module tb_des_encrypt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_vld = 1'b0;
    logic [63:0] data = '0;
    logic [63:0] key = '0;
    logic [63:0] result;
    logic        result_vld;
    bit          dec_i = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

    always #5 clk = ~clk;

    des_encrypt dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DES_DECRYPT_EN
        .decrypt    (dec_i),
`endif
        .data       (data),
        .data_vld   (data_vld),
        .key        (key),
        .result     (result),
        .result_vld (result_vld)
    );

    // ---------------- reference model ----------------
    int ip_t[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                     64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int fp_t[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                     37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    int e_t[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                     16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int p_t[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int pc1_t[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2_t[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int shifts[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int sb[8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

    // Output bit k (1-based) takes input bit tbl[k] of an in_w-bit word; result is LSB-aligned.
    function automatic logic [63:0] permute(input logic [63:0] x, input int in_w, input int tbl[$]);
        logic [63:0] y = '0;
        int n = tbl.size();
        for (int i = 0; i < n; i++) y[n-1-i] = x[in_w - tbl[i]];
        return y;
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] k, input logic [63:0] blk, input bit dec);
        logic [63:0] t;
        logic [27:0] c, d;
        logic [47:0] ks[16];
        logic [47:0] x;
        logic [31:0] l, r, f, tmp;
        logic [5:0]  b;
        t = permute(k, 64, pc1_t);
        c = t[55:28];
        d = t[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < shifts[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            t = permute({8'h00, c, d}, 56, pc2_t);
            ks[i] = t[47:0];
        end
        t = permute(blk, 64, ip_t);
        l = t[63:32];
        r = t[31:0];
        for (int i = 0; i < 16; i++) begin
            t = permute({32'h0, r}, 32, e_t);
            x = t[47:0] ^ (dec ? ks[15-i] : ks[i]);
            f = '0;
            for (int j = 0; j < 8; j++) begin
                b = x[47-6*j -: 6];
                f = {f[27:0], 4'(sb[j][{b[5], b[0]}][b[4:1]])};
            end
            t = permute({32'h0, f}, 32, p_t);
            tmp = l ^ t[31:0];
            l = r;
            r = tmp;
        end
        return permute({r, l}, 64, fp_t);
    endfunction

    // ---------------- checking and stimulus ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic bit rand_dec();
`ifdef DES_DECRYPT_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    // Called at a falling edge; strobes one block and returns at the falling edge after capture.
    task automatic start(input logic [63:0] d, input logic [63:0] k, input bit dec);
        data     = d;
        key      = k;
        dec_i    = dec;
        data_vld = 1'b1;
        @(negedge clk);
        data_vld = 1'b0;
        data     = rand64();
        key      = rand64();
        dec_i    = rand_dec();
    endtask

    // Entered 'first' falling edges after the capture edge; returns on the 16th, where the pulse must be.
    task automatic expect_block(input logic [63:0] exp, input string tag, input int first);
        int early = 0;
        if (result_vld) early++;
        for (int i = first + 1; i < 16; i++) begin
            @(negedge clk);
            if (result_vld) early++;
        end
        @(negedge clk);
        check({tag, "_early_vld"}, 64'(early), 64'd0);
        check({tag, "_vld"}, 64'(result_vld), 64'd1);
        check({tag, "_result"}, result, exp);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (result_vld) pulses++;
        end
    endtask

    initial begin
        logic [63:0] blk, k, exp_a;
        bit          dec;
        int          pulses;

        // Reset, then idle with no strobes.
        repeat (2) @(negedge clk);
        check("rst_result", result, 64'd0);
        check("rst_vld", 64'(result_vld), 64'd0);
        rst = 1'b0;
        count_pulses(12, pulses);
        check("idle_pulses", 64'(pulses), 64'd0);
        check("idle_result", result, 64'd0);

        // Known-answer block, then the pulse must drop.
        start(KAT_PT, KAT_KEY, 1'b0);
        expect_block(KAT_CT, "kat", 0);
        @(negedge clk);
        check("kat_vld_one_cycle", 64'(result_vld), 64'd0);
        check("kat_result_hold", result, KAT_CT);

        // ASCII "computer".
        start(64'h636F6D7075746572, KAT_KEY, 1'b0);
        expect_block(des_model(KAT_KEY, 64'h636F6D7075746572, 1'b0), "ascii", 0);
        @(negedge clk);

        // Random blocks against the model.
        for (int i = 0; i < 6; i++) begin
            blk = rand64();
            k   = rand64();
            dec = rand_dec();
            start(blk, k, dec);
            expect_block(des_model(k, blk, dec), $sformatf("rand%0d", i), 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Second strobe while busy is dropped; the first result holds afterwards.
        blk   = rand64();
        k     = rand64();
        exp_a = des_model(k, blk, 1'b0);
        start(blk, k, 1'b0);
        repeat (4) @(negedge clk);
        data     = rand64();
        key      = rand64();
        data_vld = 1'b1;
        @(negedge clk);
        data_vld = 1'b0;
        expect_block(exp_a, "busy", 5);
        count_pulses(25, pulses);
        check("busy_extra_pulses", 64'(pulses), 64'd0);
        check("busy_result_hold", result, exp_a);

        // Back-to-back: each new strobe lands in the previous result_vld cycle.
        for (int i = 0; i < 4; i++) begin
            blk = rand64();
            k   = rand64();
            dec = rand_dec();
            start(blk, k, dec);
            expect_block(des_model(k, blk, dec), $sformatf("b2b%0d", i), 0);
        end
        @(negedge clk);
        check("b2b_vld_drop", 64'(result_vld), 64'd0);

        // Reset during round 8 aborts the block and clears result.
        start(rand64(), rand64(), 1'b0);
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_result", result, 64'd0);
        check("midrst_vld", 64'(result_vld), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        count_pulses(25, pulses);
        check("midrst_pulses", 64'(pulses), 64'd0);
        check("midrst_result_after", result, 64'd0);

        // Core recovers after the abort.
        start(KAT_PT, KAT_KEY, 1'b0);
        expect_block(KAT_CT, "kat_after_rst", 0);

`ifdef DES_DECRYPT_EN
        @(negedge clk);
        start(KAT_CT, KAT_KEY, 1'b1);
        expect_block(KAT_PT, "kat_decrypt", 0);
        blk = rand64();
        k   = rand64();
        start(des_model(k, blk, 1'b0), k, 1'b1);
        expect_block(blk, "roundtrip", 0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
